// File: rtl/tmds_decoder.sv
// TMDS channel receiver: hunts for word alignment using control-token runs and
// a bitslip request to the deserializer, then decodes 10-bit words to pixel/control data.
module tmds_decoder #(
    parameter int LOCK_TOKENS    = 16,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int SLIP_WAIT      = 16,
    parameter int REFRESH_RUN    = 4,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    output logic       bitslip,
    output logic       aligned,
    output logic [7:0] dout,
    output logic       de,
    output logic       c0,
    output logic       c1
);
    localparam int TOK_MAX = (LOCK_TOKENS > REFRESH_RUN) ? LOCK_TOKENS : REFRESH_RUN;
    localparam int TW = $clog2(TOK_MAX) + 1;
    localparam int SW = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int WW = $clog2(SLIP_WAIT) + 1;
    localparam int LW = $clog2(LOSS_TIMEOUT) + 1;

    localparam logic [TW-1:0] LOCK_N    = TW'(LOCK_TOKENS);
    localparam logic [TW-1:0] REFRESH_N = TW'(REFRESH_RUN);
    localparam logic [SW-1:0] SEARCH_N  = SW'(SEARCH_TIMEOUT - 1);
    localparam logic [WW-1:0] WAIT_N    = WW'(SLIP_WAIT - 1);
    localparam logic [LW-1:0] LOSS_N    = LW'(LOSS_TIMEOUT - 1);

    typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;

    state_t        state_q;
    logic [TW-1:0] tok_run_q, tok_run_d;
    logic [SW-1:0] search_cnt_q, search_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [LW-1:0] loss_cnt_q, loss_cnt_d;
    logic          bitslip_q, aligned_q, de_q, c0_q, c1_q;
    logic [7:0]    dout_q;

    logic       is_tok;
    logic [1:0] tok_cc;
    logic [7:0] q, dec;
    logic       lock_hit, search_hit, wait_hit, refresh, loss_hit, dec_en;

    always_comb begin
        is_tok = 1'b1;
        tok_cc = 2'b00;
        case (din)
            10'b1101010100: tok_cc = 2'b00;
            10'b0010101011: tok_cc = 2'b01;
            10'b0101010100: tok_cc = 2'b10;
            10'b1010101011: tok_cc = 2'b11;
            default:        is_tok = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        q      = din[9] ? ~din[7:0] : din[7:0];
        dec    = 8'h00;
        dec[0] = q[0];
        for (int i = 1; i < 8; i++)
            dec[i] = din[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end

    always_comb begin
        tok_run_d    = is_tok ? ((&tok_run_q) ? tok_run_q : tok_run_q + TW'(1)) : '0;
        search_cnt_d = (&search_cnt_q) ? search_cnt_q : search_cnt_q + SW'(1);
        wait_cnt_d   = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + WW'(1);
        loss_cnt_d   = (&loss_cnt_q) ? loss_cnt_q : loss_cnt_q + LW'(1);
        lock_hit     = tok_run_d >= LOCK_N;
        search_hit   = search_cnt_q >= SEARCH_N;
        wait_hit     = wait_cnt_q >= WAIT_N;
        refresh      = tok_run_d >= REFRESH_N;
        loss_hit     = !refresh && (loss_cnt_q >= LOSS_N);
        // Decode only words whose result lands while aligned stays high.
        dec_en       = (state_q == LOCKED) && !loss_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEARCH;
            tok_run_q    <= '0;
            search_cnt_q <= '0;
            wait_cnt_q   <= '0;
            loss_cnt_q   <= '0;
            bitslip_q    <= 1'b0;
            aligned_q    <= 1'b0;
            dout_q       <= 8'h00;
            de_q         <= 1'b0;
            c0_q         <= 1'b0;
            c1_q         <= 1'b0;
        end else begin
            bitslip_q <= 1'b0;
            case (state_q)
                SEARCH: begin
                    tok_run_q    <= tok_run_d;
                    search_cnt_q <= search_cnt_d;
                    if (lock_hit) begin
                        state_q      <= LOCKED;
                        aligned_q    <= 1'b1;
                        search_cnt_q <= '0;
                        loss_cnt_q   <= '0;
                    end else if (search_hit) begin
                        state_q      <= SLIP;
                        bitslip_q    <= 1'b1;
                        tok_run_q    <= '0;
                        search_cnt_q <= '0;
                    end
                end
                SLIP: begin
                    state_q    <= WAIT;
                    wait_cnt_q <= '0;
                end
                WAIT: begin
                    if (wait_hit) begin
                        state_q      <= SEARCH;
                        tok_run_q    <= '0;
                        search_cnt_q <= '0;
                        wait_cnt_q   <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                LOCKED: begin
                    tok_run_q  <= tok_run_d;
                    loss_cnt_q <= refresh ? '0 : loss_cnt_d;
                    if (loss_hit) begin
                        state_q      <= SEARCH;
                        aligned_q    <= 1'b0;
                        tok_run_q    <= '0;
                        search_cnt_q <= '0;
                        loss_cnt_q   <= '0;
                    end
                end
                default: state_q <= SEARCH;
            endcase

            if (!dec_en) begin
                de_q   <= 1'b0;
                dout_q <= 8'h00;
                c0_q   <= 1'b0;
                c1_q   <= 1'b0;
            end else if (is_tok) begin
                de_q   <= 1'b0;
                dout_q <= 8'h00;
                c0_q   <= tok_cc[0];
                c1_q   <= tok_cc[1];
            end else begin
                de_q   <= 1'b1;
                dout_q <= dec;
            end
        end
    end

    assign bitslip = bitslip_q;
    assign aligned = aligned_q;
    assign dout    = dout_q;
    assign de      = de_q;
    assign c0      = c0_q;
    assign c1      = c1_q;
endmodule
